// File: rtl/dmem_responder.sv
// Word-addressed data memory with a post-reset clear sweep, byte-lane writes,
// a one-cycle write trace port and a sticky out-of-range flag.
module dmem_responder #(
  parameter int unsigned DEPTH = 3072,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_DATA_ADDR,
  input  logic [3:0]  MEM_BYTE_EN,
  input  logic [31:0] MEM_WRITE_DATA,
  input  logic [31:0] MEM_INST_ADDR,
  output logic [31:0] RD,
  output logic        busy,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        oob_err
);

  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ccnt_q, ccnt_d;

  logic [31:0] mem [DEPTH];

  logic [31:0] offset;
  logic [29:0] word_idx;
  logic [CW-1:0] widx;
  logic        in_range;
  logic [31:0] stored;
  logic [31:0] merged;
  logic        wr_accept;
  logic        oob_hit;

  logic        trace_valid_q;
  logic [31:0] trace_pc_q, trace_addr_q, trace_data_q;
  logic        oob_q;

  // Address decode: only the word index participates, byte offset is dropped.
  assign offset   = MEM_DATA_ADDR - BASE;
  assign word_idx = offset[31:2];
  assign widx     = word_idx[CW-1:0];
  assign in_range = (MEM_DATA_ADDR >= BASE) && ({2'b00, word_idx} < DEPTH);
  assign stored   = mem[widx];

  logic unused_bits;
  assign unused_bits = ^{offset[1:0], word_idx};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = MEM_BYTE_EN[i] ? MEM_WRITE_DATA[8*i +: 8] : stored[8*i +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StClear;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
    end
  end

  // Next-state logic: sweep one word per cycle, leave on the last word.
  always_comb begin
    state_d = state_q;
    ccnt_d  = ccnt_q;
    unique case (state_q)
      StClear: begin
        ccnt_d = ccnt_q + CW'(1);
        if (ccnt_q == LastIdx) begin
          state_d = StIdle;
          ccnt_d  = '0;
        end
      end
      StIdle:  ;
      default: state_d = StClear;
    endcase
  end

  // Output logic. busy also covers a reset held low while still in StIdle.
  always_comb begin
    busy      = (state_q == StClear) || !reset;
    RD        = '0;
    wr_accept = 1'b0;
    oob_hit   = 1'b0;
    if (state_q == StIdle) begin
      if (in_range) RD = stored;
      wr_accept = reset && (MEM_BYTE_EN != 4'b0000) && in_range;
      // An all-zero address with no enables is an idle bus, not a read.
      oob_hit   = reset && !in_range &&
                  ((MEM_BYTE_EN != 4'b0000) || (MEM_DATA_ADDR != 32'h0));
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[ccnt_q] <= '0;
    end else if (wr_accept) begin
      mem[widx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
      oob_q         <= 1'b0;
    end else begin
      trace_valid_q <= wr_accept;
      if (wr_accept) begin
        trace_pc_q   <= MEM_INST_ADDR;
        trace_addr_q <= {MEM_DATA_ADDR[31:2], 2'b00};
        trace_data_q <= merged;
      end
      oob_q <= oob_q | oob_hit;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;
  assign oob_err     = oob_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: clear sweep, lane writes, trace port,
// out-of-range handling and reset during the sweep.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 3072;

  logic        clk;
  logic        reset;
  logic [31:0] MEM_DATA_ADDR;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] MEM_INST_ADDR;
  logic [31:0] RD;
  logic        busy;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        oob_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(
    .DEPTH(DEPTH),
    .BASE (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .MEM_DATA_ADDR (MEM_DATA_ADDR),
    .MEM_BYTE_EN   (MEM_BYTE_EN),
    .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .MEM_INST_ADDR (MEM_INST_ADDR),
    .RD            (RD),
    .busy          (busy),
    .trace_valid   (trace_valid),
    .trace_pc      (trace_pc),
    .trace_addr    (trace_addr),
    .trace_data    (trace_data),
    .oob_err       (oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input logic [31:0] pc);
    MEM_DATA_ADDR  = addr;
    MEM_BYTE_EN    = be;
    MEM_WRITE_DATA = data;
    MEM_INST_ADDR  = pc;
    @(posedge clk);
    #1;
    MEM_BYTE_EN = 4'b0000;
  endtask

  task automatic read_at(input logic [31:0] addr);
    MEM_DATA_ADDR = addr;
    MEM_BYTE_EN   = 4'b0000;
    #1;
  endtask

  // Counts busy-high samples after a reset release; optionally pokes a write mid-sweep.
  task automatic count_busy(input bit inject, output int n, output bit saw_trace);
    n = 0;
    saw_trace = 1'b0;
    for (int c = 0; c < int'(DEPTH) + 16; c++) begin
      @(negedge clk);
      if (trace_valid) saw_trace = 1'b1;
      if (!busy) break;
      n++;
      if (inject && n == 5) begin
        MEM_DATA_ADDR  = 32'h40;
        MEM_BYTE_EN    = 4'b1111;
        MEM_WRITE_DATA = 32'hFFFF_FFFF;
        MEM_INST_ADDR  = 32'h4000;
      end else if (inject && n == 6) begin
        MEM_BYTE_EN   = 4'b0000;
        MEM_DATA_ADDR = 32'h0;
      end
    end
  endtask

  initial begin
    int n;
    bit saw;
    int bad;

    reset          = 1'b0;
    MEM_DATA_ADDR  = '0;
    MEM_BYTE_EN    = '0;
    MEM_WRITE_DATA = '0;
    MEM_INST_ADDR  = '0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_trace_valid", 32'(trace_valid), 32'd0);
    check("rst_trace_pc", trace_pc, 32'h0);
    check("rst_trace_addr", trace_addr, 32'h0);
    check("rst_trace_data", trace_data, 32'h0);
    check("rst_oob", 32'(oob_err), 32'd0);
    check("rst_rd", RD, 32'h0);
    reset = 1'b1;

    count_busy(1'b0, n, saw);
    check("sweep_len", 32'(n), 32'(DEPTH));
    check("sweep_no_trace", 32'(saw), 32'd0);

    bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      read_at(32'(i) * 32'd4);
      if (RD !== 32'h0) bad++;
    end
    check("clear_all_zero", 32'(bad), 32'd0);
    check("clear_busy_low", 32'(busy), 32'd0);
    check("inrange_read_no_oob", 32'(oob_err), 32'd0);

    @(posedge clk);
    #1;

    // Full-word write and trace
    do_write(32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h3000);
    read_at(32'h10);
    check("w1_rd", RD, 32'hDEAD_BEEF);
    check("w1_tv", 32'(trace_valid), 32'd1);
    check("w1_tpc", trace_pc, 32'h3000);
    check("w1_taddr", trace_addr, 32'h10);
    check("w1_tdata", trace_data, 32'hDEAD_BEEF);

    // Back-to-back partial-lane writes to the same word
    do_write(32'h12, 4'b1100, 32'h1234_0000, 32'h3004);
    read_at(32'h10);
    check("w2_rd", RD, 32'h1234_BEEF);
    check("w2_tv", 32'(trace_valid), 32'd1);
    check("w2_taddr", trace_addr, 32'h10);
    check("w2_tdata", trace_data, 32'h1234_BEEF);
    check("w2_tpc", trace_pc, 32'h3004);

    do_write(32'h11, 4'b0010, 32'h0000_AA00, 32'h3008);
    read_at(32'h10);
    check("w3_rd", RD, 32'h1234_AAEF);
    check("w3_tv", 32'(trace_valid), 32'd1);
    check("w3_tdata", trace_data, 32'h1234_AAEF);
    check("w3_tpc", trace_pc, 32'h3008);

    // Same-cycle read returns the pre-write value
    MEM_DATA_ADDR  = 32'h20;
    MEM_BYTE_EN    = 4'b1111;
    MEM_WRITE_DATA = 32'hCAFE_F00D;
    MEM_INST_ADDR  = 32'h300C;
    #1;
    check("rw_same_old", RD, 32'h0);
    @(posedge clk);
    #1;
    MEM_BYTE_EN = 4'b0000;
    check("rw_same_new", RD, 32'hCAFE_F00D);
    check("rw_tdata", trace_data, 32'hCAFE_F00D);
    check("rw_taddr", trace_addr, 32'h20);

    @(posedge clk);
    #1;
    check("tv_one_cycle", 32'(trace_valid), 32'd0);

    // Out-of-range write
    check("oob_before", 32'(oob_err), 32'd0);
    do_write(DEPTH * 4, 4'b1111, 32'h5555_5555, 32'h3010);
    check("oob_no_trace", 32'(trace_valid), 32'd0);
    check("oob_set", 32'(oob_err), 32'd1);
    check("oob_tdata_held", trace_data, 32'hCAFE_F00D);
    read_at(32'h10);
    check("oob_mem_10", RD, 32'h1234_AAEF);
    read_at(32'h20);
    check("oob_mem_20", RD, 32'hCAFE_F00D);
    read_at(32'h0);
    check("oob_mem_0", RD, 32'h0);
    read_at(DEPTH * 4);
    check("oob_rd_zero", RD, 32'h0);
    MEM_DATA_ADDR = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("oob_sticky", 32'(oob_err), 32'd1);

    // Reset from idle, then reset again at sweep cycle 100
    reset = 1'b0;
    #1;
    check("rst_hold_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("rst2_oob_clr", 32'(oob_err), 32'd0);
    check("rst2_tv", 32'(trace_valid), 32'd0);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_sweep_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    count_busy(1'b1, n, saw);
    check("resweep_len", 32'(n), 32'(DEPTH));
    check("resweep_no_trace", 32'(saw), 32'd0);
    read_at(32'h40);
    check("resweep_wr_ignored", RD, 32'h0);
    read_at(32'h10);
    check("resweep_cleared_10", RD, 32'h0);
    check("resweep_oob_clear", 32'(oob_err), 32'd0);

    // Out-of-range read sets the sticky flag
    @(posedge clk);
    #1;
    read_at(DEPTH * 4 + 4);
    @(posedge clk);
    #1;
    MEM_DATA_ADDR = 32'h0;
    check("oob_read_set", 32'(oob_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 3072, giving the number of 32-bit words stored.
REQ-002 The block SHALL have parameter BASE, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port MEM_DATA_ADDR, input, 32 bits: byte address of the access.
REQ-006 The block SHALL have port MEM_BYTE_EN, input, 4 bits: per-lane write enables; 4'b0000 = read/no write.
REQ-007 The block SHALL have port MEM_WRITE_DATA, input, 32 bits: lane-aligned write data.
REQ-008 The block SHALL have port MEM_INST_ADDR, input, 32 bits: PC of the accessing instruction, used for trace only.
REQ-009 The block SHALL have port RD, output, 32 bits: the full word at the addressed location.
REQ-010 The block SHALL have port busy, output, 1 bit: high while the clear sweep runs.
REQ-011 The block SHALL have port trace_valid, output, 1 bit: one-cycle pulse after each accepted write.
REQ-012 The block SHALL have ports trace_pc, trace_addr and trace_data, output, 32 bits each: the PC, the word-aligned byte address and the merged word of that write.
REQ-013 The block SHALL have port oob_err, output, 1 bit: sticky flag for an out-of-range access.

Function
REQ-014 The word index SHALL be (MEM_DATA_ADDR - BASE) >> 2; bits [1:0] are ignored for indexing.
REQ-015 An access SHALL be in range when MEM_DATA_ADDR >= BASE and the word index < DEPTH.
REQ-016 The block SHALL use two states, CLEAR and IDLE, with a clear counter ccnt of width ceil(log2(DEPTH)).
REQ-017 In CLEAR, each cycle SHALL write 0 to word ccnt and then increment ccnt.
REQ-018 When CLEAR writes word DEPTH-1, the block SHALL move to IDLE on that edge; the sweep takes exactly DEPTH cycles.
REQ-019 busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-020 In CLEAR, RD SHALL be 0, MEM_BYTE_EN SHALL be ignored, and trace_valid SHALL stay 0.
REQ-021 In IDLE, RD SHALL be combinational: the stored word at the index when in range, otherwise 0.
REQ-022 In IDLE, with MEM_BYTE_EN != 0 and an in-range address, lane i of the word SHALL become MEM_WRITE_DATA[8i+7:8i] when MEM_BYTE_EN[i]=1, else keep its old value, at the rising edge.
REQ-023 A read in the same cycle as a write to the same word SHALL return the pre-write value; the new value is visible from the next cycle.
REQ-024 On the edge after an accepted write, trace_valid SHALL be 1 for exactly one cycle.
REQ-025 With that pulse, trace_pc SHALL be the write's MEM_INST_ADDR, trace_addr SHALL be {MEM_DATA_ADDR[31:2],2'b00}, and trace_data SHALL be the merged word.
REQ-026 Back-to-back writes SHALL produce back-to-back trace pulses with no lost entries.
REQ-027 An out-of-range write in IDLE SHALL be dropped with no memory change and no trace pulse.
REQ-028 oob_err SHALL set to 1 on the edge after any out-of-range access in IDLE (MEM_BYTE_EN nonzero, or a read) and hold until reset.
REQ-029 A read SHALL be counted for REQ-028 only when MEM_BYTE_EN == 0 and MEM_DATA_ADDR != 0 (an idle bus drives 0).

Reset
REQ-030 reset=0 at a rising edge SHALL force state to CLEAR, set ccnt to 0, set trace_valid to 0, set trace_pc, trace_addr and trace_data to 0, and set oob_err to 0.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep from word 0.
REQ-032 While reset is held low, busy SHALL be 1 and no writes SHALL be accepted.
REQ-033 Memory contents SHALL not be guaranteed to be zero until busy falls.

Verification
REQ-034 Reset low 1 cycle, release -> busy=1 for exactly DEPTH cycles, then 0; RD=0 at every address.
REQ-035 Write addr 0x10, BE=1111, data 0xDEADBEEF, PC 0x3000 -> next cycle RD@0x10=0xDEADBEEF, trace_valid=1, trace_pc=0x3000, trace_addr=0x10, trace_data=0xDEADBEEF.
REQ-036 Then write addr 0x12, BE=1100, data 0x12340000 -> RD@0x10=0x1234BEEF; then write addr 0x11, BE=0010, data 0x0000AA00 -> RD@0x10=0x1234AAEF.
REQ-037 Write and read 0x20 in the same cycle, old value 0 -> RD=0 that cycle and the new value the next cycle.
REQ-038 Write to byte address DEPTH*4 -> no trace pulse, memory unchanged, oob_err=1 and sticky until reset.
REQ-039 Reset asserted at sweep cycle 100 -> busy stays high for a further full DEPTH cycles after release; a write attempted meanwhile is ignored.
